ace_snapshot_encoder: RTL

Encodes the Jupiter Ace RAM image (default 0x2000–0x7FFF) into the RLE-compressed .ACE stream byte by byte. It is the write-side counterpart of the core's .ACE loader: marker 0xED, count, value; 0xED 0x00 terminates. It sits between the machine RAM read port and the HPS upload path. Its output stream, fed back through the loader, must reproduce the RAM image exactly.

---
 rtl/ace_snapshot_encoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ace_snapshot_encoder.sv
// ace_snapshot_encoder: scans a RAM window and emits the RLE .ACE stream.
// Runs of MIN_RUN+ bytes (or any MARKER byte) become MARKER,count,value.
module ace_snapshot_encoder #(
  parameter logic [15:0] START_ADDR = 16'h2000,
  parameter logic [15:0] END_ADDR   = 16'h7FFF,
  parameter logic [7:0]  MARKER     = 8'hED,
  parameter int unsigned MIN_RUN    = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_count,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] MinRun = 8'(MIN_RUN);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_LATCH, S_FLUSH,
    S_FL_MARK, S_FL_CNT, S_FL_VAL, S_FL_LIT,
    S_TERM_MARK, S_TERM_ZERO
  } state_t;

  state_t     state, state_n;
  logic [7:0] data_n;
  logic       valid_n;
  logic       flush_end;
  logic [7:0] cur, nxt, run, lit;
  logic       first, pend, fin;

  logic xfer, is_last, esc, extend;
  assign xfer    = out_valid & out_ready;
  assign is_last = (mem_addr == END_ADDR);
  assign esc     = (run >= MinRun) || (cur == MARKER);
  assign extend  = first || ((mem_data == cur) && (run != 8'hFF));
  assign mem_rd  = (state == S_READ);

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and next registered output byte
  always_comb begin
    state_n   = state;
    data_n    = out_data;
    valid_n   = out_valid;
    flush_end = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_n = S_READ;
      S_READ:  state_n = S_LATCH;
      S_LATCH: begin
        if (extend && is_last) state_n = S_FLUSH;
        else if (extend)       state_n = S_READ;
        else                   state_n = S_FLUSH;
      end
      S_FLUSH: begin
        valid_n = 1'b1;
        if (esc) begin
          state_n = S_FL_MARK;
          data_n  = MARKER;
        end else begin
          state_n = S_FL_LIT;
          data_n  = cur;
        end
      end
      S_FL_MARK: if (xfer) begin
        state_n = S_FL_CNT;
        data_n  = run;
      end
      S_FL_CNT: if (xfer) begin
        state_n = S_FL_VAL;
        data_n  = cur;
      end
      S_FL_VAL: if (xfer) flush_end = 1'b1;
      S_FL_LIT: if (xfer && lit == 8'd1) flush_end = 1'b1;
      S_TERM_MARK: if (xfer) begin
        state_n = S_TERM_ZERO;
        data_n  = 8'h00;
      end
      S_TERM_ZERO: if (xfer) begin
        state_n = S_IDLE;
        valid_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
    if (flush_end) begin
      if (pend && fin) begin
        state_n = S_FLUSH;
        valid_n = 1'b0;
      end else if (pend) begin
        state_n = S_READ;
        valid_n = 1'b0;
      end else begin
        state_n = S_TERM_MARK;
        data_n  = MARKER;
        valid_n = 1'b1;
      end
    end
  end

  // Run tracking, address, counters and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_addr  <= START_ADDR;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_count <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur       <= 8'h00;
      nxt       <= 8'h00;
      run       <= 8'h00;
      lit       <= 8'h00;
      first     <= 1'b0;
      pend      <= 1'b0;
      fin       <= 1'b0;
    end else begin
      out_data  <= data_n;
      out_valid <= valid_n;
      done      <= 1'b0;
      if (xfer) out_count <= out_count + 16'd1;
      unique case (state)
        S_IDLE: if (start) begin
          out_count <= 16'h0000;
          mem_addr  <= START_ADDR;
          busy      <= 1'b1;
          first     <= 1'b1;
          pend      <= 1'b0;
          fin       <= 1'b0;
        end
        S_LATCH: begin
          if (extend) begin
            if (first) begin
              cur   <= mem_data;
              run   <= 8'd1;
              first <= 1'b0;
            end else begin
              run <= run + 8'd1;
            end
            if (is_last) fin <= 1'b1;
            else mem_addr <= mem_addr + 16'd1;
          end else begin
            nxt  <= mem_data;
            pend <= 1'b1;
            fin  <= is_last;
          end
        end
        S_FLUSH:  lit <= run;
        S_FL_LIT: if (xfer) lit <= lit - 8'd1;
        S_TERM_ZERO: if (xfer) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
      if (flush_end && pend) begin
        cur  <= nxt;
        run  <= 8'd1;
        pend <= 1'b0;
        if (!fin) mem_addr <= mem_addr + 16'd1;
      end
    end
  end

endmodule
